// File: rtl/alu_result_stage.sv
// Registered result stage behind the 32-bit ALU: captures R/Cout/F, derives status flags,
// and hands them downstream over valid/ready. Define ALU_STAGE_SKID_EN for a two-entry skid version.
module alu_result_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_R,
  input  logic             in_Cout,
  input  logic [2:0]       in_F,
  input  logic             in_A31,
  input  logic             in_B31,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_R,
  output logic [2:0]       out_F,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);

  typedef struct packed {
    logic [31:0] r;
    logic [2:0]  f;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
  } entry_t;

  entry_t           in_entry;
  entry_t           main_q, main_d;
  logic             main_vld_q, main_vld_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    in_entry       = '0;
    in_entry.r     = in_R;
    in_entry.f     = in_F;
    in_entry.zero  = (in_R == 32'd0);
    in_entry.neg   = in_R[31];
    case (in_F)
      3'b000: begin
        in_entry.carry = in_Cout;
        in_entry.ovf   = (in_A31 == in_B31) & (in_R[31] != in_A31);
      end
      3'b001: begin
        in_entry.carry = in_Cout;
        in_entry.ovf   = (in_A31 != in_B31) & (in_R[31] != in_A31);
      end
      default: ;
    endcase
  end

  assign accept  = in_valid & in_ready;
  assign count_d = count_q + {{(CNT_W-1){1'b0}}, accept};

`ifdef ALU_STAGE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_vld_q, skid_vld_d;
  logic   pop;

  assign pop      = main_vld_q & out_ready;
  assign in_ready = ~skid_vld_q;

  // Skid only fills on a stall with main occupied, and drains into main on the next pop.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      if (pop) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (main_vld_q) begin
      if (pop && accept) begin
        main_d = in_entry;
      end else if (pop) begin
        main_vld_d = 1'b0;
      end else if (accept) begin
        skid_d     = in_entry;
        skid_vld_d = 1'b1;
      end
    end else if (accept) begin
      main_d     = in_entry;
      main_vld_d = 1'b1;
    end
  end

  // NOTE: skid data is never visible on the ports until moved into main, so only its valid bit is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_vld_q <= 1'b0;
    end else begin
      skid_vld_q <= skid_vld_d;
    end
    skid_q <= skid_d;
  end
`else
  assign in_ready = ~main_vld_q | out_ready;

  always_comb begin
    main_vld_d = accept | (main_vld_q & ~out_ready);
    main_d     = accept ? in_entry : main_q;
  end
`endif

  // NOTE: state is updated only with non-blocking <= here; blocking = stays in the always_comb blocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      count_q    <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      count_q    <= count_d;
    end
  end

  assign out_valid = main_vld_q;
  assign out_R     = main_q.r;
  assign out_F     = main_q.f;
  assign out_zero  = main_q.zero;
  assign out_neg   = main_q.neg;
  assign out_carry = main_q.carry;
  assign out_ovf   = main_q.ovf;
  assign out_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed flag vectors, backpressure, reset, then random traffic
// checked against a capacity-limited FIFO model with flags derived from signed/unsigned arithmetic.
module tb_alu_result_stage;

  localparam int CW = 4;
`ifdef ALU_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_R = '0;
  logic          in_Cout = 1'b0;
  logic [2:0]    in_F = '0;
  logic          in_A31 = 1'b0;
  logic          in_B31 = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_R;
  logic [2:0]    out_F;
  logic          out_zero, out_neg, out_carry, out_ovf;
  logic [CW-1:0] out_count;

  always #5 clk = ~clk;

  alu_result_stage #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_R(in_R), .in_Cout(in_Cout), .in_F(in_F), .in_A31(in_A31), .in_B31(in_B31),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_R(out_R), .out_F(out_F),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_ovf(out_ovf),
    .out_count(out_count)
  );

  typedef struct packed {
    logic [31:0] r;
    logic [2:0]  f;
    logic [3:0]  zncv;
  } exp_t;

  exp_t        q[$];
  logic [31:0] seen[$];
  int          cnt = 0;
  int          total = 0;
  int          bad = 0;
  logic        post_rst = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_r(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~(a | b);
      3'd6: return a & ~b;
      default: return a | ~b;
    endcase
  endfunction

  function automatic logic alu_cout(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua = longint'(a);
    longint unsigned ub = longint'(b);
    if (f == 3'd0) return ((ua + ub) >> 32) != 0;
    if (f == 3'd1) return ub > ua;
    return 1'b0;
  endfunction

  function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s  = (f == 3'd0) ? sa + sb : sa - sb;
    logic   z, n, c, v;
    e.r = alu_r(f, a, b);
    e.f = f;
    z   = (e.r == 0);
    n   = ($signed(e.r) < 0);
    c   = (f <= 3'd1) ? alu_cout(f, a, b) : 1'b0;
    v   = (f <= 3'd1) && (s > 64'sd2147483647 || s < -64'sd2147483648);
    e.zncv = {z, n, c, v};
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy, input logic rst, output logic acc);
    logic exp_rdy;
    @(posedge clk);
    #1;
    reset     = rst;
    in_valid  = v;
    in_F      = v ? f : 3'($urandom);
    in_R      = v ? alu_r(f, a, b) : $urandom;
    in_Cout   = v ? alu_cout(f, a, b) : 1'($urandom);
    in_A31    = a[31];
    in_B31    = b[31];
    out_ready = ordy;
    @(negedge clk);
    exp_rdy = (CAP == 1) ? (q.size() == 0 || ordy) : (q.size() < 2);
    acc = 1'b0;
    if (!rst) begin
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_count", 32'(out_count), 32'(cnt));
      if (q.size() > 0) begin
        check("out_R", out_R, q[0].r);
        check("out_F_flags", 32'({out_F, out_zero, out_neg, out_carry, out_ovf}), 32'({q[0].f, q[0].zncv}));
        if (ordy) seen.push_back(out_R);
      end
      if (post_rst) begin
        check("rst_out_R", out_R, 32'd0);
        check("rst_out_F_flags", 32'({out_F, out_zero, out_neg, out_carry, out_ovf}), 32'd0);
      end
      acc = v && exp_rdy;
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) begin
        q.push_back(model(f, a, b));
        cnt = (cnt + 1) % (1 << CW);
      end
    end else begin
      q.delete();
      cnt = 0;
    end
    post_rst = rst;
  endtask

  task automatic directed(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic [3:0] exp_zncv);
    logic acc;
    cycle(1'b1, f, a, b, 1'b1, 1'b0, acc);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, acc);
    check({tag, "_R"}, out_R, exp_r);
    check({tag, "_zncv"}, 32'({out_zero, out_neg, out_carry, out_ovf}), 32'(exp_zncv));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic acc;
    int   k;
    logic [31:0] a, b;

    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, acc);

    directed("add_ovf",  3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101);
    directed("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010);
    directed("sub_ovf",  3'b001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001);
    directed("sub_brw",  3'b001, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0010);
    directed("logic_and", 3'b010, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 4'b0100);

    // Backpressure: results 1..4, downstream stalled for three cycles after the first accept.
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    seen.delete();
    k = 0;
    for (int c = 0; c < 30; c++) begin
      cycle(k < 4, 3'b010, 32'(k + 1), 32'(k + 1), !(c >= 1 && c <= 3), 1'b0, acc);
      if (acc) k++;
    end
    check("bp_count", 32'(out_count), 32'd4);
    check("bp_seen_n", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("bp_order", (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF, 32'(i + 1));

    // Reset while full and stalled; in_valid stays high across the reset edge.
    cycle(1'b1, 3'b000, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, acc);
    cycle(1'b1, 3'b000, 32'h0000_0009, 32'h0000_0001, 1'b0, 1'b0, acc);
    cycle(1'b1, 3'b011, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b1, acc);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, acc);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Random traffic; long enough to wrap the narrow counter several times.
    for (int c = 0; c < 600; c++) begin
      a = pick();
      b = pick();
      cycle($urandom_range(0, 9) < 7, 3'($urandom), a, b, $urandom_range(0, 9) < 6, 1'b0, acc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
